// File: rtl/prim_assembler_if.sv
// Vertex/colour FIFO read port plus rasterizer primitive handshake for prim_assembler.
// master = assembler side, slave = FIFO/rasterizer side.
interface prim_assembler_if #(
  parameter int VTX_W     = 96,
  parameter int COL_W     = 96,
  parameter int NUM_VERTS = 3,
  parameter int CNT_W     = 16
);
  logic                       vertex_empty;
  logic                       color_empty;
  logic [VTX_W-1:0]           vertex_in;
  logic [COL_W-1:0]           color_in;
  logic                       dequeue;
  logic                       strip_mode;
  logic                       vertex_rd_en;
  logic                       color_rd_en;
  logic                       ready;
  logic [NUM_VERTS*VTX_W-1:0] vertex_out;
  logic [NUM_VERTS*COL_W-1:0] color_out;
  logic [CNT_W-1:0]           prim_count;

  modport master (
    input  vertex_empty, color_empty, vertex_in, color_in, dequeue, strip_mode,
    output vertex_rd_en, color_rd_en, ready, vertex_out, color_out, prim_count
  );

  modport slave (
    output vertex_empty, color_empty, vertex_in, color_in, dequeue, strip_mode,
    input  vertex_rd_en, color_rd_en, ready, vertex_out, color_out, prim_count
  );
endinterface

// File: rtl/prim_assembler.sv
// Assembles NUM_VERTS vertex/colour pairs into a held primitive, with list and strip reuse modes.
// Optional macro PRIM_ASM_WINDING_FIX_EN: swap presented slots 0/1 on odd strip primitives.
module prim_assembler #(
  parameter int VTX_W     = 96,
  parameter int COL_W     = 96,
  parameter int NUM_VERTS = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  prim_assembler_if.master bus
);

  localparam int IDX_W = $clog2(NUM_VERTS + 1);

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_rd_en;
  logic             r_ready;
  logic [CNT_W-1:0] r_cnt;
  logic [VTX_W-1:0] r_vslot [NUM_VERTS];
  logic [COL_W-1:0] r_cslot [NUM_VERTS];

  logic w_fetch;
  logic w_capture;
  logic w_done;
  logic w_deq;

  logic [NUM_VERTS*VTX_W-1:0] w_vout;
  logic [NUM_VERTS*COL_W-1:0] w_cout;

  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    w_deq       = 1'b0;
    case (r_state)
      ISSUE: begin
        if (r_idx == IDX_W'(NUM_VERTS)) begin
          w_done      = 1'b1;
          w_state_nxt = HOLD;
        end else if (!bus.vertex_empty && !bus.color_empty) begin
          w_fetch     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      // Empty flags lag the pop, so WAIT never looks at them.
      WAIT:    w_state_nxt = CAPTURE;
      CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = ISSUE;
      end
      HOLD: begin
        if (bus.dequeue) begin
          w_deq       = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      default: w_state_nxt = ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ISSUE;
      r_idx   <= '0;
      r_rd_en <= 1'b0;
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rd_en <= w_fetch;
      if (w_done)
        r_ready <= 1'b1;
      else if (w_deq)
        r_ready <= 1'b0;
      if (w_capture)
        r_idx <= r_idx + 1'b1;
      else if (w_deq)
        r_idx <= bus.strip_mode ? IDX_W'(NUM_VERTS - 1) : '0;
      if (w_deq)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Strip reuse shifts the window down by one; list mode leaves stale slots until refilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_VERTS; k++) begin
        r_vslot[k] <= '0;
        r_cslot[k] <= '0;
      end
    end else begin
      if (w_deq && bus.strip_mode) begin
        for (int k = 0; k < NUM_VERTS - 1; k++) begin
          r_vslot[k] <= r_vslot[k+1];
          r_cslot[k] <= r_cslot[k+1];
        end
      end
      for (int k = 0; k < NUM_VERTS; k++) begin
        if (w_capture && (r_idx == IDX_W'(k))) begin
          r_vslot[k] <= bus.vertex_in;
          r_cslot[k] <= bus.color_in;
        end
      end
    end
  end

`ifdef PRIM_ASM_WINDING_FIX_EN
  logic r_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_parity <= 1'b0;
    else if (w_deq)
      r_parity <= bus.strip_mode ? ~r_parity : 1'b0;
  end

  always_comb begin
    for (int k = 0; k < NUM_VERTS; k++) begin
      w_vout[k*VTX_W +: VTX_W] = r_vslot[k];
      w_cout[k*COL_W +: COL_W] = r_cslot[k];
    end
    // Odd strip primitives flip the first two vertices to keep winding consistent.
    if (r_parity) begin
      w_vout[0     +: VTX_W] = r_vslot[1];
      w_vout[VTX_W +: VTX_W] = r_vslot[0];
      w_cout[0     +: COL_W] = r_cslot[1];
      w_cout[COL_W +: COL_W] = r_cslot[0];
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_VERTS; k++) begin
      w_vout[k*VTX_W +: VTX_W] = r_vslot[k];
      w_cout[k*COL_W +: COL_W] = r_cslot[k];
    end
  end
`endif

  assign bus.vertex_rd_en = r_rd_en;
  assign bus.color_rd_en  = r_rd_en;
  assign bus.ready        = r_ready;
  assign bus.vertex_out   = w_vout;
  assign bus.color_out    = w_cout;
  assign bus.prim_count   = r_cnt;

endmodule

// File: tb/tb_prim_assembler.sv
// Scoreboard bench for prim_assembler: FIFO model, directed primitives, monitor on ready rise.
module tb_prim_assembler;

  localparam int VW = 96;
  localparam int CW = 96;
  localparam int NV = 3;
  localparam int CN = 4;
  localparam int PW = NV * VW;
`ifdef PRIM_ASM_WINDING_FIX_EN
  localparam bit FIX_EN = 1'b1;
`else
  localparam bit FIX_EN = 1'b0;
`endif

  typedef struct {
    logic [PW-1:0] v;
    logic [PW-1:0] c;
    logic [CN-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  prim_assembler_if #(.VTX_W(VW), .COL_W(CW), .NUM_VERTS(NV), .CNT_W(CN)) bus ();

  prim_assembler #(.VTX_W(VW), .COL_W(CW), .NUM_VERTS(NV), .CNT_W(CN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  exp_t sb[$];

  // FIFO model: read data appears the cycle after rd_en.
  logic [VW-1:0] vmem [64];
  logic [CW-1:0] cmem [64];
  int vwr = 0;
  int vrd = 0;
  int cwr = 0;
  int crd = 0;

  assign bus.vertex_empty = (vwr == vrd);
  assign bus.color_empty  = (cwr == crd);

  always @(posedge clk) begin
    if (bus.vertex_rd_en) begin
      bus.vertex_in <= vmem[vrd];
      vrd <= vrd + 1;
    end
    if (bus.color_rd_en) begin
      bus.color_in <= cmem[crd];
      crd <= crd + 1;
    end
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_v(input logic [VW-1:0] d);
    vmem[vwr] = d;
    vwr = vwr + 1;
  endtask

  task automatic push_c(input logic [CW-1:0] d);
    cmem[cwr] = d;
    cwr = cwr + 1;
  endtask

  task automatic exp_prim(input logic [VW-1:0] v0, input logic [VW-1:0] v1, input logic [VW-1:0] v2,
                          input logic [CW-1:0] c0, input logic [CW-1:0] c1, input logic [CW-1:0] c2,
                          input int cnt, input bit par);
    exp_t e;
    if (par && FIX_EN) begin
      e.v = {v2, v0, v1};
      e.c = {c2, c0, c1};
    end else begin
      e.v = {v2, v1, v0};
      e.c = {c2, c1, c0};
    end
    e.cnt = CN'(cnt);
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ready"},  PW'(bus.ready), '0);
    chk({pfx, "_vrd"},    PW'(bus.vertex_rd_en), '0);
    chk({pfx, "_crd"},    PW'(bus.color_rd_en), '0);
    chk({pfx, "_vout"},   bus.vertex_out, '0);
    chk({pfx, "_cout"},   bus.color_out, '0);
    chk({pfx, "_count"},  PW'(bus.prim_count), '0);
  endtask

  // Counts negedges until ready is seen high; clears dequeue after the first edge.
  task automatic wait_ready(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.dequeue = 1'b0;
      n++;
      if (bus.ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: ready still 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic do_dequeue(input bit strip, output int low);
    int n;
    bus.strip_mode = strip;
    bus.dequeue    = 1'b1;
    wait_ready(n);
    low = n - 1;
  endtask

  // Monitor: compares each newly presented primitive against the scoreboard.
  initial begin : monitor
    bit prev_rd;
    bit prev_rdy;
    logic [PW-1:0] hold_v;
    exp_t e;
    prev_rd  = 1'b0;
    prev_rdy = 1'b0;
    hold_v   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rd  = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (bus.vertex_rd_en) begin
          rd_cnt++;
          chk("rd_pair", PW'(bus.color_rd_en), PW'(1));
          chk("rd_gap", PW'(prev_rd), '0);
        end
        if (bus.ready && !prev_rdy) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_prim: got vertex_out %h, expected none", bus.vertex_out);
          end else begin
            e = sb.pop_front();
            chk("prim_vertex", bus.vertex_out, e.v);
            chk("prim_color",  bus.color_out,  e.c);
            chk("prim_count",  PW'(bus.prim_count), PW'(e.cnt));
          end
          hold_v = bus.vertex_out;
        end else if (bus.ready) begin
          chk("hold_stable", bus.vertex_out, hold_v);
        end
        prev_rd  = bus.vertex_rd_en;
        prev_rdy = bus.ready;
      end
    end
  end

  initial begin : stim
    int n;
    int snap;
    int stuck;
    logic [VW-1:0] mv [3];
    logic [CW-1:0] mc [3];
    bit par;

    rst_n          = 1'b0;
    bus.dequeue    = 1'b0;
    bus.strip_mode = 1'b0;

    // Basic fill
    push_v(1); push_v(2); push_v(3);
    push_c('hA); push_c('hB); push_c('hC);
    exp_prim(1, 2, 3, 'hA, 'hB, 'hC, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    wait_ready(n);
    chk("fill_latency", PW'(n), PW'(10));
    chk("fill_rd_pulses", PW'(rd_cnt), PW'(3));

    // Strip: one fetch, window shifts to 2/3/4
    push_v(4); push_c('hD);
    exp_prim(2, 3, 4, 'hB, 'hC, 'hD, 1, 1'b1);
    snap = rd_cnt;
    do_dequeue(1'b1, n);
    chk("strip_low", PW'(n), PW'(4));
    chk("strip_rd_pulses", PW'(rd_cnt - snap), PW'(1));

    // List: full refetch
    push_v(5); push_v(6); push_v(7);
    push_c('hE); push_c('hF); push_c('h10);
    exp_prim(5, 6, 7, 'hE, 'hF, 'h10, 2, 1'b0);
    do_dequeue(1'b0, n);
    chk("list_low", PW'(n), PW'(10));

    // Stall on empty colour FIFO
    push_v(8); push_v(9); push_v(10);
    push_c('h21); push_c('h22);
    exp_prim(8, 9, 10, 'h21, 'h22, 'h23, 3, 1'b0);
    snap = rd_cnt;
    bus.strip_mode = 1'b0;
    bus.dequeue    = 1'b1;
    @(negedge clk);
    bus.dequeue = 1'b0;
    stuck = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready) stuck++;
    end
    chk("stall_ready", PW'(stuck), '0);
    chk("stall_rd_pulses", PW'(rd_cnt - snap), PW'(2));
    push_c('h23);
    wait_ready(n);
    chk("stall_resume", PW'(n), PW'(4));

    // Dequeue during fill is ignored
    push_v(11); push_v(12); push_v(13);
    push_c('h31); push_c('h32); push_c('h33);
    exp_prim(11, 12, 13, 'h31, 'h32, 'h33, 4, 1'b0);
    bus.strip_mode = 1'b0;
    bus.dequeue    = 1'b1;
    @(negedge clk);
    bus.dequeue = 1'b0;
    repeat (3) @(negedge clk);
    bus.strip_mode = 1'b1;
    bus.dequeue    = 1'b1;
    wait_ready(n);
    chk("ignored_deq_count", PW'(bus.prim_count), PW'(4));

    // Async reset while a read is in flight
    push_v(40); push_v(41); push_v(42);
    push_c('h50); push_c('h51); push_c('h52);
    bus.strip_mode = 1'b0;
    bus.dequeue    = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.dequeue = 1'b0;
      n++;
      if (bus.vertex_rd_en) break;
    end
    chk("rst_wait_reached", PW'(bus.vertex_rd_en), PW'(1));
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    exp_prim(40, 41, 42, 'h50, 'h51, 'h52, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_capture_after_rst", bus.vertex_out, '0);
    wait_ready(n);

    // 16 strip dequeues wrap the 4-bit counter
    mv[0] = 40; mv[1] = 41; mv[2] = 42;
    mc[0] = 'h50; mc[1] = 'h51; mc[2] = 'h52;
    par = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_v(VW'(60 + i));
      push_c(CW'(80 + i));
      mv[0] = mv[1]; mv[1] = mv[2]; mv[2] = VW'(60 + i);
      mc[0] = mc[1]; mc[1] = mc[2]; mc[2] = CW'(80 + i);
      par = ~par;
      exp_prim(mv[0], mv[1], mv[2], mc[0], mc[1], mc[2], (i + 1) % 16, par);
      do_dequeue(1'b1, n);
    end
    chk("wrap_count", PW'(bus.prim_count), '0);

    repeat (2) @(negedge clk);
    chk("sb_drained", PW'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prim_assembler.md
Name: prim_assembler

Overview:
- Pulls vertex/colour pairs from the separate vertex and colour FIFOs and assembles one primitive of NUM_VERTS vertices.
- Holds the primitive stable for the rasterizer and raises ready; the rasterizer consumes it by pulsing dequeue.
- Generalises the fixed 3-vertex, 96-bit triangle register in width and vertex count.
- Adds strip mode: after each dequeue, NUM_VERTS-1 vertices are reused and only one new vertex is fetched.

Parameters:
- VTX_W, 96, vertex word width.
- COL_W, 96, colour word width.
- NUM_VERTS, 3, vertices per primitive (legal 2..8).
- CNT_W, 16, width of the primitive counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vertex_empty  in  1  vertex FIFO empty flag.
- color_empty  in  1  colour FIFO empty flag.
- vertex_in  in  VTX_W  vertex FIFO read data, valid the cycle after vertex_rd_en is high.
- color_in  in  COL_W  colour FIFO read data, same timing as vertex_in.
- dequeue  in  1  rasterizer consumed the primitive; honoured only while ready=1.
- strip_mode  in  1  sampled on an honoured dequeue; 1 = reuse vertices.
- vertex_rd_en  out  1  registered one-cycle read pulse to the vertex FIFO.
- color_rd_en  out  1  always equal to vertex_rd_en.
- ready  out  1  all NUM_VERTS slots valid.
- vertex_out  out  NUM_VERTS*VTX_W  slot k at bits [k*VTX_W +: VTX_W].
- color_out  out  NUM_VERTS*COL_W  slot k at bits [k*COL_W +: COL_W].
- prim_count  out  CNT_W  number of primitives dequeued.

Behaviour:
- Reset (async, rst_n=0):
  - state=ISSUE, fill index idx=0.
  - ready, vertex_rd_en, color_rd_en, all slots and prim_count = 0.
  - Any FIFO read in flight is discarded; no capture follows reset release.
- State machine and per-vertex timing:
  - ISSUE: if idx==NUM_VERTS, then ready<=1 and go to HOLD. Else if vertex_empty==0 and color_empty==0, then rd_en<=1 and go to WAIT. Else stay in ISSUE with rd_en=0.
  - WAIT: rd_en is high this cycle; rd_en<=0; go to CAPTURE. Empty flags are ignored here because they lag the pop.
  - CAPTURE: slot[idx]<=vertex_in/color_in, idx<=idx+1, go to ISSUE.
  - Each vertex costs 3 cycles. A primitive becomes ready 3*NUM_VERTS+1 cycles after fill starts with both FIFOs non-empty.
  - Both FIFOs are popped together, so each pair is read exactly once. There is never more than one read in flight.
- HOLD:
  - ready=1; slots and rd_en stay constant.
  - On dequeue=1: ready<=0, prim_count<=prim_count+1 (wraps at 2^CNT_W), go to ISSUE.
  - If strip_mode=0 at that dequeue: idx<=0; old slot contents are kept until overwritten.
  - If strip_mode=1: in the same edge slot[k]<=slot[k+1] for k=0..NUM_VERTS-2, and idx<=NUM_VERTS-1, so only the last slot is refetched.
- Boundary cases:
  - dequeue while ready=0 is ignored: no state change, no count.
  - The first primitive after reset always fetches NUM_VERTS vertices, whatever strip_mode is.
  - A FIFO going empty mid-primitive stalls in ISSUE indefinitely, with captured slots retained and ready=0.
  - Outputs change only at CAPTURE and at an honoured dequeue. Slot values are stable for the whole time ready=1.

Optional Feature:
- Macro: PRIM_ASM_WINDING_FIX_EN.
- Defined:
  - A one-bit parity register toggles on every honoured dequeue taken with strip_mode=1.
  - It clears on reset and on any honoured dequeue taken with strip_mode=0.
  - While parity=1, vertex_out/color_out slots 0 and 1 are presented swapped, preserving triangle-strip winding order. Internal storage is unchanged.
- Undefined: no parity logic; slots are always presented in storage order.

Test Plan:
- Basic fill: FIFOs preloaded with V=1,2,3 and C=0xA,0xB,0xC, NUM_VERTS=3, release reset. Expect ready=1 at cycle 10 after release; vertex_out slots 0/1/2 = 1/2/3; colour slots 0xA/0xB/0xC; exactly 3 rd_en pulses, never on consecutive cycles.
- List mode: dequeue with strip_mode=0, FIFOs holding 4,5,6. Expect ready low for 10 cycles, then slots = 4/5/6 and prim_count=1.
- Strip mode: after slots 1/2/3, dequeue with strip_mode=1, FIFO holding 4. Expect exactly one rd_en pulse and slots = 2/3/4 four cycles later. With PRIM_ASM_WINDING_FIX_EN, presented slots = 3/2/4.
- Stall: colour FIFO empty after 2 pops. Expect ready=0 and rd_en=0 indefinitely. Push colour 0xC; expect capture within 3 cycles and ready one cycle later.
- Ignored dequeue and async reset: pulse dequeue during fill → prim_count unchanged. Assert rst_n low mid-WAIT → all outputs 0 immediately, no capture after release.
- Counter wrap: CNT_W=4, run 16 strip-mode dequeues → prim_count returns to 0.
